axil_cfg_sequencer: RTL and testbench
=====================================

Name: axil_cfg_sequencer

Overview:
Hardware AXI4-Lite master that replays a programmed register script (writes, reads, read-compares and waits) against up to NUM_TARGETS AXI4-Lite slave ports, e.g. the RHD and RHS controller register banks. It brings acquisition and stimulation configuration sequences into fabric so a session can start without a processor. The script is loaded into an internal command RAM and executed on start. Status and error outputs report progress and completion.

Parameters:
NUM_TARGETS, 2, number of AXI4-Lite slave ports driven (1..16)
ADDR_W, 12, AXI address width
DEPTH, 64, command RAM entries (power of two)
TIMEOUT, 1024, max cycles waiting on any AXI ready/valid before a timeout error
CMD_W, 39+ADDR_W, command word width (derived; do not override)

Ports:
aclk  in  1  system clock
areset  in  1  synchronous, active-high reset
load_we  in  1  command RAM write strobe (ignored while busy)
load_addr  in  log2(DEPTH)  command RAM write index
load_data  in  CMD_W  command word: [2:0] op, [6:3] target, [6+ADDR_W:7] addr, [CMD_W-1:7+ADDR_W] data
start  in  1  one-cycle pulse; starts execution at entry 0
abort  in  1  stop at the next safe point
halt_on_err  in  1  1 = stop on first error; 0 = count it and continue
busy / done / error  out  1 each  status; done and error are sticky until the next start
pc  out  log2(DEPTH)  index of the executing entry
err_count  out  16  saturating error count
last_rdata  out  32  data from the most recent read
m_awaddr / m_araddr  out  ADDR_W  shared address
m_awprot / m_arprot  out  3  tied to 0
m_wdata  out  32  shared write data; m_wstrb out 4, tied to 0xF
m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready  out  NUM_TARGETS  per-target one-hot
m_awready, m_wready, m_bvalid, m_arready, m_rvalid  in  NUM_TARGETS  per-target
m_bresp, m_rresp  in  2*NUM_TARGETS  per-target responses
m_rdata  in  32*NUM_TARGETS  per-target read data

Behaviour:
- Reset: state IDLE. All outputs 0, including pc, err_count, last_rdata and every valid/ready. The command RAM contents are not cleared.
- States: IDLE, FETCH, EXEC, WR, WRESP, RD, RDATA, WAIT, DONE, ERROR.
- IDLE: start -> FETCH with pc=0, busy=1, done=error=0, err_count=0. start while busy is ignored.
- FETCH: 1-cycle RAM read latency, then EXEC.
- EXEC op decode:
  - 0 NOP: advance.
  - 1 WRITE: go to WR.
  - 2 READ: go to RD.
  - 3 READ_CMP: go to RD and compare the result.
  - 4 WAIT: go to WAIT.
  - 7 END: go to DONE.
  - 5, 6, or target >= NUM_TARGETS: illegal-command error.
- WR: assert awvalid[t] and wvalid[t] together in the cycle after EXEC. Drop each one independently on the cycle its ready is seen. When both have handshaken -> WRESP with bready[t]=1. On bvalid: bresp!=0 is an error; otherwise advance.
- RD: arvalid[t] until arready -> RDATA with rready[t]=1. On rvalid: latch last_rdata. rresp!=0 is an error. For READ_CMP, rdata != data is an error. Otherwise advance.
- WAIT: count data cycles; data=0 advances in 1 cycle. abort is honoured immediately in this state.
- Timeout: a counter restarts on every state entry. If it reaches TIMEOUT in WR, WRESP, RD or RDATA, that is an error. On a timeout, drop all valid/ready signals the next cycle.
- Error handling: err_count increments by 1 and saturates at 0xFFFF. If halt_on_err=1 -> ERROR, with error=1 and busy=0. Otherwise advance.
- Advance: pc+1 -> FETCH. After entry DEPTH-1 there is no implicit END: pc wraps to 0 -> DONE.
- abort: sampled at every advance point and in WAIT -> IDLE, busy=0, done=0. An in-flight AXI transaction always completes first; no valid is ever retracted before its handshake.
- DONE/ERROR: busy=0. start re-runs the script.
- Only one target's handshake bits are ever nonzero at a time.
- areset mid-transaction: all valids/readies are 0 the cycle after the reset edge.

Test Plan:
- Script [WRITE t0 0x4 0x22222222; WRITE t0 0x8 0x2; WRITE t1 0x0 0x29; END] with zero-wait slaves -> three AW/W handshakes with exact address/data on the correct one-hot target; done=1, err_count=0, pc=3.
- READ_CMP t1 0x0 0x29 where the slave returns 0x29, then again where it returns 0x28 with halt_on_err=1 -> the first passes; the second gives error=1, err_count=1, last_rdata=0x28, and stops at that pc.
- Slave raises wready 5 cycles before awready, then bresp=2'b10 with halt_on_err=0 -> valids drop independently; err_count=1; the script continues to done.
- Slave never asserts awready, TIMEOUT=1024 -> error asserted at 1024 cycles after awvalid rises; awvalid low on the next cycle.
- WAIT 100 then abort pulsed at cycle 50 -> IDLE within 1 cycle; the next WRITE is never issued; done=0.
- Script of 64 NOPs with no END -> done after pc wraps. Separately, start mid-run and load_we while busy are ignored, and areset during WRESP clears all outputs.

Source files
------------

// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite master that replays a register script from an internal command RAM
// against NUM_TARGETS slave ports, so a session can be configured without a CPU.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | command RAM read in flight
// EXEC  | decode the fetched command
// WR    | AW and/or W still outstanding
// WRESP | waiting on the B response
// RD    | AR outstanding
// RDATA | waiting on the R beat
// WAIT  | counting down a WAIT command
// DONE  | script finished (sticky until start)
// ERROR | halted on an error (sticky until start)
module axil_cfg_sequencer #(
  parameter int NUM_TARGETS = 2,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 64,
  parameter int TIMEOUT     = 1024,
  parameter int CMD_W       = 39 + ADDR_W
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       load_we,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [CMD_W-1:0]           load_data,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       halt_on_err,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH)-1:0]   pc,
  output logic [15:0]                err_count,
  output logic [31:0]                last_rdata,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic [2:0]                 m_awprot,
  output logic [ADDR_W-1:0]          m_araddr,
  output logic [2:0]                 m_arprot,
  output logic [31:0]                m_wdata,
  output logic [3:0]                 m_wstrb,
  output logic [NUM_TARGETS-1:0]     m_awvalid,
  output logic [NUM_TARGETS-1:0]     m_wvalid,
  output logic [NUM_TARGETS-1:0]     m_bready,
  output logic [NUM_TARGETS-1:0]     m_arvalid,
  output logic [NUM_TARGETS-1:0]     m_rready,
  input  logic [NUM_TARGETS-1:0]     m_awready,
  input  logic [NUM_TARGETS-1:0]     m_wready,
  input  logic [NUM_TARGETS-1:0]     m_bvalid,
  input  logic [NUM_TARGETS-1:0]     m_arready,
  input  logic [NUM_TARGETS-1:0]     m_rvalid,
  input  logic [2*NUM_TARGETS-1:0]   m_bresp,
  input  logic [2*NUM_TARGETS-1:0]   m_rresp,
  input  logic [32*NUM_TARGETS-1:0]  m_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);
  localparam logic [4:0] NT = 5'(NUM_TARGETS);
  localparam logic [PW-1:0] PC_LAST = PW'(DEPTH - 1);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_WR   = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_RDC  = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;
  localparam logic [2:0] OP_END  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WR, S_WRESP, S_RD, S_RDATA, S_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t state, state_n;

  logic [CMD_W-1:0]  cmd_ram [DEPTH];
  logic [CMD_W-1:0]  cmd_q;
  logic [PW-1:0]     pc_q, pc_n;
  logic              aw_q, aw_n, w_q, w_n, b_q, b_n, ar_q, ar_n, r_q, r_n;
  logic [TW-1:0]     tmr_q;
  logic [31:0]       wait_q;
  logic              abort_q;
  logic [15:0]       err_cnt_q;
  logic [31:0]       rdata_q;
  logic              err_hit, adv, run_start, rd_latch;
  logic              busy_i, tmr_zero, bad_tgt;

  logic [2:0]        cmd_op;
  logic [3:0]        cmd_tgt;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_data;

  logic [NUM_TARGETS-1:0] sel;
  logic              aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic [1:0]        b_resp, r_resp;
  logic [31:0]       r_data;

  assign cmd_op   = cmd_q[2:0];
  assign cmd_tgt  = cmd_q[6:3];
  assign cmd_addr = cmd_q[6+ADDR_W:7];
  assign cmd_data = cmd_q[CMD_W-1:7+ADDR_W];
  assign bad_tgt  = ({1'b0, cmd_tgt} >= NT);

  assign busy_i   = !(state inside {S_IDLE, S_DONE, S_ERROR});
  assign tmr_zero = (tmr_q == '0);

  always_comb begin
    sel    = '0;
    b_resp = '0;
    r_resp = '0;
    r_data = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      sel[i] = (cmd_tgt == 4'(i));
      if (sel[i]) begin
        b_resp = m_bresp[2*i +: 2];
        r_resp = m_rresp[2*i +: 2];
        r_data = m_rdata[32*i +: 32];
      end
    end
  end

  assign aw_rdy = |(m_awready & sel);
  assign w_rdy  = |(m_wready & sel);
  assign b_vld  = |(m_bvalid & sel);
  assign ar_rdy = |(m_arready & sel);
  assign r_vld  = |(m_rvalid & sel);

  always_ff @(posedge aclk) begin
    if (load_we && !busy_i) cmd_ram[load_addr] <= load_data;
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc_q;
    aw_n      = aw_q;
    w_n       = w_q;
    b_n       = b_q;
    ar_n      = ar_q;
    r_n       = r_q;
    err_hit   = 1'b0;
    adv       = 1'b0;
    run_start = 1'b0;
    rd_latch  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_n   = S_FETCH;
          pc_n      = '0;
          run_start = 1'b1;
        end
      end
      S_FETCH: state_n = S_EXEC;
      S_EXEC: begin
        if (bad_tgt) begin
          err_hit = 1'b1;
        end else begin
          case (cmd_op)
            OP_NOP:  adv = 1'b1;
            OP_WR: begin
              state_n = S_WR;
              aw_n    = 1'b1;
              w_n     = 1'b1;
            end
            OP_RD, OP_RDC: begin
              state_n = S_RD;
              ar_n    = 1'b1;
            end
            OP_WAIT: state_n = S_WAIT;
            OP_END:  state_n = S_DONE;
            default: err_hit = 1'b1;
          endcase
        end
      end
      S_WR: begin
        // AW and W retire independently; B is only requested once both are gone
        if (aw_q && aw_rdy) aw_n = 1'b0;
        if (w_q && w_rdy) w_n = 1'b0;
        if ((!aw_q || aw_rdy) && (!w_q || w_rdy)) begin
          state_n = S_WRESP;
          b_n     = 1'b1;
        end else if (tmr_zero) begin
          aw_n    = 1'b0;
          w_n     = 1'b0;
          err_hit = 1'b1;
        end
      end
      S_WRESP: begin
        if (b_vld) begin
          b_n = 1'b0;
          if (b_resp != 2'b00) err_hit = 1'b1;
          else adv = 1'b1;
        end else if (tmr_zero) begin
          b_n     = 1'b0;
          err_hit = 1'b1;
        end
      end
      S_RD: begin
        if (ar_rdy) begin
          ar_n    = 1'b0;
          r_n     = 1'b1;
          state_n = S_RDATA;
        end else if (tmr_zero) begin
          ar_n    = 1'b0;
          err_hit = 1'b1;
        end
      end
      S_RDATA: begin
        if (r_vld) begin
          r_n      = 1'b0;
          rd_latch = 1'b1;
          if (r_resp != 2'b00 || (cmd_op == OP_RDC && r_data != cmd_data)) err_hit = 1'b1;
          else adv = 1'b1;
        end else if (tmr_zero) begin
          r_n     = 1'b0;
          err_hit = 1'b1;
        end
      end
      S_WAIT: begin
        if (abort || abort_q) state_n = S_IDLE;
        else if (wait_q == '0) adv = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (err_hit) begin
      if (halt_on_err) state_n = S_ERROR;
      else adv = 1'b1;
    end

    // every advance is a safe point: no AXI channel is outstanding here
    if (adv) begin
      if (abort || abort_q) begin
        state_n = S_IDLE;
      end else if (pc_q == PC_LAST) begin
        pc_n    = '0;
        state_n = S_DONE;
      end else begin
        pc_n    = pc_q + 1'b1;
        state_n = S_FETCH;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= S_IDLE;
      pc_q      <= '0;
      cmd_q     <= '0;
      aw_q      <= 1'b0;
      w_q       <= 1'b0;
      b_q       <= 1'b0;
      ar_q      <= 1'b0;
      r_q       <= 1'b0;
      tmr_q     <= '0;
      wait_q    <= '0;
      abort_q   <= 1'b0;
      err_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      aw_q  <= aw_n;
      w_q   <= w_n;
      b_q   <= b_n;
      ar_q  <= ar_n;
      r_q   <= r_n;

      if (state == S_FETCH) cmd_q <= cmd_ram[pc_q];

      if (state_n != state) tmr_q <= T_LOAD;
      else if (!tmr_zero) tmr_q <= tmr_q - 1'b1;

      if (state == S_EXEC && state_n == S_WAIT) wait_q <= cmd_data;
      else if (state == S_WAIT && wait_q != '0) wait_q <= wait_q - 32'd1;

      // a pulse that lands mid-transaction is held until the next safe point
      if (run_start || !busy_i) abort_q <= 1'b0;
      else if (abort) abort_q <= 1'b1;

      if (run_start) err_cnt_q <= '0;
      else if (err_hit && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;

      if (rd_latch) rdata_q <= r_data;
    end
  end

  assign busy       = busy_i;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign pc         = pc_q;
  assign err_count  = err_cnt_q;
  assign last_rdata = rdata_q;

  assign m_awaddr  = cmd_addr;
  assign m_araddr  = cmd_addr;
  assign m_wdata   = cmd_data;
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign m_wstrb   = 4'hF;
  assign m_awvalid = {NUM_TARGETS{aw_q}} & sel;
  assign m_wvalid  = {NUM_TARGETS{w_q}} & sel;
  assign m_bready  = {NUM_TARGETS{b_q}} & sel;
  assign m_arvalid = {NUM_TARGETS{ar_q}} & sel;
  assign m_rready  = {NUM_TARGETS{r_q}} & sel;

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Bench for axil_cfg_sequencer: directed scripts, a configurable slave model, and a
// monitor that checks every AXI handshake against a queue of expected transfers.
module tb_axil_cfg_sequencer;

  localparam int NT    = 2;
  localparam int AW    = 12;
  localparam int DEPTH = 64;
  localparam int TOUT  = 1024;
  localparam int CW    = 39 + AW;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_WR   = 3'd1;
  localparam logic [2:0] OP_RDC  = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;
  localparam logic [2:0] OP_END  = 3'd7;

  logic           aclk = 1'b0;
  logic           areset, load_we, start, abort, halt_on_err;
  logic [5:0]     load_addr;
  logic [CW-1:0]  load_data;
  logic           busy, done, error;
  logic [5:0]     pc;
  logic [15:0]    err_count;
  logic [31:0]    last_rdata;
  logic [AW-1:0]  m_awaddr, m_araddr;
  logic [2:0]     m_awprot, m_arprot;
  logic [31:0]    m_wdata;
  logic [3:0]     m_wstrb;
  logic [NT-1:0]  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [NT-1:0]  m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [2*NT-1:0]  m_bresp, m_rresp;
  logic [32*NT-1:0] m_rdata;

  axil_cfg_sequencer #(
    .NUM_TARGETS(NT), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TOUT)
  ) dut (
    .aclk(aclk), .areset(areset), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .abort(abort), .halt_on_err(halt_on_err),
    .busy(busy), .done(done), .error(error), .pc(pc), .err_count(err_count),
    .last_rdata(last_rdata), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_rready(m_rready), .m_awready(m_awready),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_bresp(m_bresp), .m_rresp(m_rresp), .m_rdata(m_rdata)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int aw_hs_total = 0;
  int aw_only = 0;
  int onehot_viol = 0;

  logic [35:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [35:0] exp_ar[$];

  // slave behaviour knobs
  int          aw_dly = 0;
  int          w_dly = 0;
  logic        aw_never = 1'b0;
  logic        b_hold = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic [2:0] op, input logic [3:0] tgt,
                                       input logic [AW-1:0] addr, input logic [31:0] data);
    return {data, addr, tgt, op};
  endfunction

  // slave model: readies follow valids after a programmable number of cycles
  initial begin
    int aw_cnt[NT];
    int w_cnt[NT];
    m_awready = '0; m_wready = '0; m_bvalid = '0; m_arready = '0; m_rvalid = '0;
    m_bresp = '0; m_rresp = '0; m_rdata = '0;
    for (int i = 0; i < NT; i++) begin
      aw_cnt[i] = 0;
      w_cnt[i] = 0;
    end
    forever begin
      @(posedge aclk);
      #1;
      for (int i = 0; i < NT; i++) begin
        aw_cnt[i] = m_awvalid[i] ? aw_cnt[i] + 1 : 0;
        w_cnt[i]  = m_wvalid[i] ? w_cnt[i] + 1 : 0;
        m_awready[i] = m_awvalid[i] && !aw_never && (aw_cnt[i] > aw_dly);
        m_wready[i]  = m_wvalid[i] && (w_cnt[i] > w_dly);
        m_arready[i] = m_arvalid[i];
        m_bvalid[i]  = m_bready[i] && !b_hold;
        m_rvalid[i]  = m_rready[i];
      end
      m_bresp = {NT{bresp_cfg}};
      m_rresp = '0;
      m_rdata = {NT{rdata_cfg}};
    end
  end

  // monitor: handshakes seen at the negedge complete on the following posedge
  initial forever begin
    logic [35:0] e;
    logic [35:0] g;
    logic [NT-1:0] act;
    @(negedge aclk);
    act = m_awvalid | m_wvalid | m_bready | m_arvalid | m_rready;
    if ($countones(act) > 1) onehot_viol++;
    if ((|m_awvalid) && !(|m_wvalid)) aw_only++;
    for (int i = 0; i < NT; i++) begin
      if (m_awvalid[i] && m_awready[i]) begin
        aw_hs_total++;
        g = {4'(i), 20'd0, m_awaddr};
        checks++;
        if (exp_aw.size() == 0) begin
          errors++;
          $display("FAIL aw_unexpected: got 0x%0h expected no transfer", g);
        end else begin
          e = exp_aw.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL aw_xfer: got 0x%0h expected 0x%0h", g, e);
          end
        end
      end
      if (m_wvalid[i] && m_wready[i]) begin
        g = {4'(i), m_wdata};
        checks++;
        if (exp_w.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected: got 0x%0h expected no transfer", g);
        end else begin
          e = exp_w.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL w_xfer: got 0x%0h expected 0x%0h", g, e);
          end
        end
      end
      if (m_arvalid[i] && m_arready[i]) begin
        g = {4'(i), 20'd0, m_araddr};
        checks++;
        if (exp_ar.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected: got 0x%0h expected no transfer", g);
        end else begin
          e = exp_ar.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL ar_xfer: got 0x%0h expected 0x%0h", g, e);
          end
        end
      end
    end
  end

  task automatic load(input int idx, input logic [CW-1:0] cmd);
    @(negedge aclk);
    load_we = 1'b1;
    load_addr = 6'(idx);
    load_data = cmd;
    @(negedge aclk);
    load_we = 1'b0;
  endtask

  task automatic run_script(input string name, input int budget);
    int n;
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    n = 0;
    while (busy && n < budget) begin
      @(negedge aclk);
      n++;
    end
    chk({name, "_finished"}, busy, 0);
  endtask

  task automatic chk_queues(input string name);
    chk({name, "_aw_left"}, exp_aw.size(), 0);
    chk({name, "_w_left"}, exp_w.size(), 0);
    chk({name, "_ar_left"}, exp_ar.size(), 0);
  endtask

  initial begin
    int t_aw, t_err, nb, n;
    areset = 1'b1; load_we = 1'b0; start = 1'b0; abort = 1'b0; halt_on_err = 1'b1;
    load_addr = '0; load_data = '0;
    repeat (3) @(negedge aclk);
    chk("rst_status", {busy, done, error}, 3'b000);
    chk("rst_pc", pc, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_rdata", last_rdata, 0);
    chk("rst_handshake", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    areset = 1'b0;

    // three writes, zero-wait slaves
    load(0, mk(OP_WR, 4'd0, 12'h004, 32'h22222222));
    load(1, mk(OP_WR, 4'd0, 12'h008, 32'h00000002));
    load(2, mk(OP_WR, 4'd1, 12'h000, 32'h00000029));
    load(3, mk(OP_END, 4'd0, 12'h000, 32'h0));
    exp_aw.push_back({4'd0, 20'd0, 12'h004});
    exp_aw.push_back({4'd0, 20'd0, 12'h008});
    exp_aw.push_back({4'd1, 20'd0, 12'h000});
    exp_w.push_back({4'd0, 32'h22222222});
    exp_w.push_back({4'd0, 32'h00000002});
    exp_w.push_back({4'd1, 32'h00000029});
    run_script("wr3", 200);
    chk("wr3_status", {done, error}, 2'b10);
    chk("wr3_errcnt", err_count, 0);
    chk("wr3_pc", pc, 3);
    chk_queues("wr3");

    // read-compare: matching then mismatching data with halt
    load(0, mk(OP_NOP, 4'd0, 12'h000, 32'h0));
    load(1, mk(OP_RDC, 4'd1, 12'h000, 32'h00000029));
    load(2, mk(OP_END, 4'd0, 12'h000, 32'h0));
    rdata_cfg = 32'h29;
    exp_ar.push_back({4'd1, 20'd0, 12'h000});
    run_script("rdc_ok", 200);
    chk("rdc_ok_status", {done, error}, 2'b10);
    chk("rdc_ok_errcnt", err_count, 0);
    chk("rdc_ok_rdata", last_rdata, 32'h29);
    chk("rdc_ok_pc", pc, 2);
    rdata_cfg = 32'h28;
    exp_ar.push_back({4'd1, 20'd0, 12'h000});
    run_script("rdc_bad", 200);
    chk("rdc_bad_status", {done, error}, 2'b01);
    chk("rdc_bad_errcnt", err_count, 1);
    chk("rdc_bad_rdata", last_rdata, 32'h28);
    chk("rdc_bad_pc", pc, 1);
    chk_queues("rdc");

    // late awready, error bresp, continue on error
    halt_on_err = 1'b0;
    aw_dly = 5;
    bresp_cfg = 2'b10;
    load(0, mk(OP_WR, 4'd0, 12'h010, 32'h0000A5A5));
    load(1, mk(OP_NOP, 4'd0, 12'h000, 32'h0));
    load(2, mk(OP_END, 4'd0, 12'h000, 32'h0));
    exp_aw.push_back({4'd0, 20'd0, 12'h010});
    exp_w.push_back({4'd0, 32'h0000A5A5});
    aw_only = 0;
    run_script("bresp", 200);
    chk("bresp_aw_only_cycles", aw_only, 5);
    chk("bresp_status", {done, error}, 2'b10);
    chk("bresp_errcnt", err_count, 1);
    chk("bresp_pc", pc, 2);
    chk_queues("bresp");
    aw_dly = 0;
    bresp_cfg = 2'b00;

    // awready never arrives: timeout
    halt_on_err = 1'b1;
    aw_never = 1'b1;
    load(0, mk(OP_WR, 4'd0, 12'h030, 32'h00000001));
    load(1, mk(OP_END, 4'd0, 12'h000, 32'h0));
    exp_w.push_back({4'd0, 32'h00000001});
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    t_aw = -1;
    t_err = -1;
    for (int k = 0; k < 2000; k++) begin
      if (t_aw < 0 && m_awvalid[0]) t_aw = cyc;
      if (error) begin
        t_err = cyc;
        break;
      end
      @(negedge aclk);
    end
    chk("timeout_latency", 64'(t_err - t_aw), 64'(1024));
    chk("timeout_awvalid", m_awvalid, 0);
    chk("timeout_errcnt", err_count, 1);
    chk("timeout_pc", pc, 0);
    chk_queues("timeout");
    aw_never = 1'b0;

    // abort in the middle of a WAIT
    n = aw_hs_total;
    load(0, mk(OP_WAIT, 4'd0, 12'h000, 32'd100));
    load(1, mk(OP_WR, 4'd0, 12'h040, 32'h00000077));
    load(2, mk(OP_END, 4'd0, 12'h000, 32'h0));
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (49) @(negedge aclk);
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    chk("abort_status", {busy, done, error}, 3'b000);
    repeat (150) @(negedge aclk);
    chk("abort_no_write", aw_hs_total - n, 0);
    chk("abort_idle_after", {busy, done}, 2'b00);

    // 64 NOPs wrap to done; start and load while busy are ignored
    for (int k = 0; k < DEPTH; k++) load(k, mk(OP_NOP, 4'd0, 12'h000, 32'h0));
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    nb = 0;
    for (int k = 0; k < 400; k++) begin
      if (done) break;
      if (busy) nb++;
      if (k == 4) begin
        start = 1'b1;
        load_we = 1'b1;
        load_addr = 6'd5;
        load_data = mk(OP_END, 4'd0, 12'h000, 32'h0);
      end else begin
        start = 1'b0;
        load_we = 1'b0;
      end
      @(negedge aclk);
    end
    start = 1'b0;
    load_we = 1'b0;
    chk("wrap_done", {done, error}, 2'b10);
    chk("wrap_pc", pc, 0);
    chk("wrap_busy_cycles", nb, 128);

    // areset while waiting on B
    b_hold = 1'b1;
    load(0, mk(OP_WR, 4'd1, 12'h050, 32'h00000099));
    load(1, mk(OP_END, 4'd0, 12'h000, 32'h0));
    exp_aw.push_back({4'd1, 20'd0, 12'h050});
    exp_w.push_back({4'd1, 32'h00000099});
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    n = 0;
    while (!(|m_bready) && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("wresp_bready", m_bready, 2'b10);
    areset = 1'b1;
    @(negedge aclk);
    chk("wresp_rst_handshake", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    chk("wresp_rst_status", {busy, done, error}, 3'b000);
    chk("wresp_rst_pc", pc, 0);
    areset = 1'b0;
    b_hold = 1'b0;
    repeat (3) @(negedge aclk);
    chk_queues("wresp");
    chk("onehot_violations", onehot_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
